itof_pipe: RTL and testbench
============================

// Module: itof_pipe
// PURPOSE
//  Pipelined signed-int32 -> IEEE-754 single converter. Rounds to nearest, ties-to-even.
//  Sits downstream of ftoi in the FPU conversion path: ftoi -> itof_pipe.
//  Together they implement the float round/floor ops, and itof_pipe also serves the standalone itof instruction.
//  Carries a valid bit alongside the data so the FPU issue/writeback logic can track it.
//  Has a stall input for back-pressure.
// PARAMETERS
//  NSTAGE  3  pipeline depth (input to y). Only 3 is supported; an elaboration-time check fails otherwise.
// PORTS
//  clk        in   1   clock, rising-edge
//  rstn       in   1   reset; one clock domain; reset is asynchronous and active-low
//  x          in   32  signed two's-complement integer operand
//  in_valid   in   1   x is valid this cycle (sampled only when stall=0)
//  stall      in   1   1 = every pipeline register holds its value; no input is accepted
//  y          out  32  IEEE single result {sign, exp[7:0], man[22:0]}
//  out_valid  out  1   y carries a valid result
// BEHAVIOUR
//  Reset: all stage registers, y and out_valid become 0 asynchronously. No X on any output.
//  Latency: exactly 3 un-stalled cycles. With in_valid=1 at edge k and stall=0 on edges k..k+2,
//    y/out_valid are valid after edge k+2.
//  Throughput: 1 result per cycle.
//  Stall: when stall=1, every register (data and valid) holds at that edge.
//    out_valid/y stay stable while stalled. No bubble is inserted and no data is lost.
//  Invalid slots: in_valid=0 propagates as a bubble. y may keep stale data, but out_valid=0.
//  S1 (abs): s=x[31]; a=s ? -x : x, as a 32-bit unsigned value.
//    x=0x80000000 gives a=0x80000000, i.e. 2^31 with no overflow.
//  S2 (normalise): lz = leading-zero count of a (0..31; a=0 is flagged zero).
//    Register s, zero flag, lz and n=a<<lz (n[31]=1 unless zero).
//  S3 (round/pack):
//    mantissa m=n[30:8], guard g=n[7], sticky st=|n[6:0], lsb l=n[8].
//    Round up iff g & (st | l).
//    {c, m'} = {1'b0, m} + up. If c, then m'=0 and exp increments.
//    exp = 158 - lz + c, where 158 = 127+31.
//    zero -> y=0x00000000 (never -0).
//    Result is always exact or normal; no overflow, NaN or denormal is possible.
//  Simultaneous stall=1 and in_valid=1: the input is not taken.
//    The upstream must hold x/in_valid until stall=0.
//  Reset mid-operation: all in-flight results are discarded. out_valid=0 from the reset edge on.
// STRUCTURE
//  Shared package fpu_pkg:
//    - typedef fp32_t (packed struct sign/exp/man)
//    - constants FP_BIAS=127, FP_EXP_W=8, FP_MAN_W=23
//    - function fp_pack(s,e,m)
//  Sub-module lzc32: combinational 32-bit leading-zero counter.
//    Ports a[31:0] -> lz[4:0] and zero; tree of 2-bit/4-bit encoders.
//    Reusable by fadd normalisation.
//  itof_pipe: the three stage registers, the valid shift chain with a shared enable (!stall),
//    and the S3 round/pack logic.
// TESTING
//  Drive: one random int per cycle via $urandom. Also drive a random stall pattern and random in_valid.
//  Reference: $shortrealtobits(shortreal'(int_val)), taken 3 enabled cycles later. Require an exact bit match.
//  Directed:
//   x=0 -> 0x00000000;  x=1 -> 0x3F800000;  x=-1 -> 0xBF800000
//   x=0x80000000 -> 0xCF000000;  x=0x7FFFFFFF -> 0x4F000000 (round-up carry into exp)
//   x=16777217 (2^24+1) -> 0x4B800000 (tie, even down);  x=16777219 -> 0x4B800002 (tie, even up)
//   stall=1 for 5 cycles with 3 results in flight -> y/out_valid frozen; 3 results emerge in order after release
//   rstn=0 pulse with full pipe -> out_valid=0 and y=0 immediately; first post-reset input valid 3 cycles later
//  Round-trip: ftoi -> itof_pipe chain on random floats with |f|<2^23. Result equals nearest-int(f) as a float.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU types and helpers: IEEE-754 single layout and field packing.
package fpu_pkg;

  localparam int FP_BIAS  = 127;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp32_t;

  function automatic fp32_t fp_pack(input logic s,
                                    input logic [FP_EXP_W-1:0] e,
                                    input logic [FP_MAN_W-1:0] m);
    fp32_t r;
    r.sign = s;
    r.exp  = e;
    r.man  = m;
    return r;
  endfunction

endpackage

// File: rtl/itof_pipe_if.sv
// Operand/result bundle of the int->float converter, with the stall back-pressure line.
interface itof_pipe_if;
  logic [31:0] x;
  logic        in_valid;
  logic        stall;
  logic [31:0] y;
  logic        out_valid;

  modport master (output x, in_valid, stall, input y, out_valid);
  modport slave  (input x, in_valid, stall, output y, out_valid);
endinterface

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter built as a tree of pairwise merges.
module lzc32 (
  input  logic [31:0] a,
  output logic [4:0]  lz,
  output logic        zero
);
  logic [15:0]      z1;
  logic [15:0]      c1;
  logic [7:0]       z2;
  logic [7:0][1:0]  c2;
  logic [3:0]       z3;
  logic [3:0][2:0]  c3;
  logic [1:0]       z4;
  logic [1:0][3:0]  c4;

  // Each merge: if the upper half is all zero, count = half width + lower count.
  for (genvar i = 0; i < 16; i++) begin : g_l1
    assign z1[i] = ~(a[2*i+1] | a[2*i]);
    assign c1[i] = ~a[2*i+1];
  end
  for (genvar i = 0; i < 8; i++) begin : g_l2
    assign z2[i] = z1[2*i+1] & z1[2*i];
    assign c2[i] = z1[2*i+1] ? {1'b1, c1[2*i]} : {1'b0, c1[2*i+1]};
  end
  for (genvar i = 0; i < 4; i++) begin : g_l3
    assign z3[i] = z2[2*i+1] & z2[2*i];
    assign c3[i] = z2[2*i+1] ? {1'b1, c2[2*i]} : {1'b0, c2[2*i+1]};
  end
  for (genvar i = 0; i < 2; i++) begin : g_l4
    assign z4[i] = z3[2*i+1] & z3[2*i];
    assign c4[i] = z3[2*i+1] ? {1'b1, c3[2*i]} : {1'b0, c3[2*i+1]};
  end

  assign zero = z4[1] & z4[0];
  assign lz   = z4[1] ? {1'b1, c4[0]} : {1'b0, c4[1]};
endmodule

// File: rtl/itof_pipe.sv
// Three-stage signed int32 -> IEEE single converter, round-to-nearest-even, with global stall.
module itof_pipe
  import fpu_pkg::*;
#(
  parameter int NSTAGE = 3
) (
  input  logic       clk,
  input  logic       rstn,
  itof_pipe_if.slave bus
);
  if (NSTAGE != 3) begin : g_nstage_chk
    $error("itof_pipe: only NSTAGE=3 is supported");
  end

  localparam logic [FP_EXP_W-1:0] EXP_TOP = FP_EXP_W'(FP_BIAS + 31);

  logic                en;
  logic                s1_v, s1_s;
  logic [31:0]         s1_a;
  logic                s2_v, s2_s, s2_z;
  logic [4:0]          s2_lz;
  logic [30:0]         s2_n;
  logic                y_v;
  logic [31:0]         y_q;

  logic [31:0]         abs_x;
  logic [4:0]          lz;
  logic                zero;
  logic [30:0]         norm;
  logic [FP_MAN_W-1:0] man_t, man_r;
  logic                guard, sticky, lsb, up, carry;
  logic [FP_EXP_W-1:0] exp_r;
  logic [31:0]         y_d;

  assign en    = ~bus.stall;
  assign abs_x = bus.x[31] ? (~bus.x + 32'd1) : bus.x;

  lzc32 u_lzc (.a(s1_a), .lz(lz), .zero(zero));

  // The normalised MSB is implicit, so only the 31 bits below it are carried.
  assign norm = s1_a[30:0] << lz;

  assign man_t  = s2_n[30:8];
  assign lsb    = s2_n[8];
  assign guard  = s2_n[7];
  assign sticky = |s2_n[6:0];
  assign up     = guard & (sticky | lsb);
  assign {carry, man_r} = {1'b0, man_t} + {{FP_MAN_W{1'b0}}, up};
  assign exp_r  = EXP_TOP - FP_EXP_W'(s2_lz) + FP_EXP_W'(carry);
  assign y_d    = s2_z ? 32'h0 : fp_pack(s2_s, exp_r, man_r);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v  <= 1'b0;
      s1_s  <= 1'b0;
      s1_a  <= '0;
      s2_v  <= 1'b0;
      s2_s  <= 1'b0;
      s2_z  <= 1'b0;
      s2_lz <= '0;
      s2_n  <= '0;
      y_v   <= 1'b0;
      y_q   <= '0;
    end else if (en) begin
      s1_v  <= bus.in_valid;
      s1_s  <= bus.x[31];
      s1_a  <= abs_x;
      s2_v  <= s1_v;
      s2_s  <= s1_s;
      s2_z  <= zero;
      s2_lz <= lz;
      s2_n  <= norm;
      y_v   <= s2_v;
      y_q   <= y_d;
    end
  end

  assign bus.y         = y_q;
  assign bus.out_valid = y_v;
endmodule

// File: tb/tb_itof_pipe.sv
// Bench for itof_pipe: directed corner values, stall/reset scenarios, random traffic vs. arithmetic model.
module tb_itof_pipe;
  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  itof_pipe_if bus ();
  itof_pipe #(.NSTAGE(3)) u_dut (.clk(clk), .rstn(rstn), .bus(bus));

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] q_val[$];
  int          q_age[$];
  logic        exp_valid;
  logic [31:0] exp_x;

  // Exact integer rounding: keep 24 significant bits, round the rest to nearest-even.
  function automatic logic [31:0] ref_int(input logic [31:0] v);
    logic   s;
    longint mag, q, rem, half;
    int     e, sh;
    if (v == 32'h0) return 32'h0;
    s   = v[31];
    mag = longint'($signed(v));
    if (mag < 0) mag = -mag;
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      q = mag << (23 - e);
    end else begin
      sh   = e - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    return {s, 8'(e + 127), q[22:0]};
  endfunction

  // For |n| < 2^24 the double is exactly representable in single; rebias its fields.
  function automatic logic [31:0] ref_dbl(input int n);
    logic [63:0] b;
    logic [10:0] e;
    if (n == 0) return 32'h0;
    b = $realtobits(real'(n));
    e = b[62:52];
    return {b[63], 8'(e - 11'd896), b[51:29]};
  endfunction

  // Drive one cycle; the model ages every accepted value by one per enabled edge.
  task automatic tick(input logic st, input logic iv, input logic [31:0] xv);
    bus.stall    = st;
    bus.in_valid = iv;
    bus.x        = xv;
    @(posedge clk);
    if (!st) begin
      foreach (q_age[i]) q_age[i]++;
      while (q_age.size() > 0 && q_age[0] > 3) begin
        void'(q_age.pop_front());
        void'(q_val.pop_front());
      end
      if (iv) begin
        q_val.push_back(xv);
        q_age.push_back(1);
      end
    end
    @(negedge clk);
    exp_valid = (q_age.size() > 0) && (q_age[0] == 3);
    exp_x     = exp_valid ? q_val[0] : 32'h0;
  endtask

  task automatic test_reset();
    rstn         = 1'b0;
    bus.stall    = 1'b0;
    bus.in_valid = 1'b0;
    bus.x        = 32'h0;
    q_val.delete();
    q_age.delete();
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    n_checks++;
    if (bus.y !== 32'h0) begin
      n_err++;
      $display("FAIL reset_y: got %h expected 00000000", bus.y);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] din [7];
    logic [31:0] dexp[7];
    int k = 0;
    din  = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd16777217, 32'd16777219};
    dexp = '{32'h0, 32'h3F800000, 32'hBF800000, 32'hCF000000, 32'h4F000000, 32'h4B800000, 32'h4B800002};
    for (int i = 0; i < 10; i++) begin
      if (i < 7) tick(1'b0, 1'b1, din[i]);
      else       tick(1'b0, 1'b0, $urandom);
      n_checks++;
      if (bus.out_valid !== exp_valid) begin
        n_err++;
        $display("FAIL directed_valid[%0d]: got %b expected %b", i, bus.out_valid, exp_valid);
      end
      if (exp_valid && k < 7) begin
        n_checks++;
        if (bus.y !== dexp[k]) begin
          n_err++;
          $display("FAIL directed_y x=%h: got %h expected %h", din[k], bus.y, dexp[k]);
        end
        k++;
      end
    end
    n_checks++;
    if (k !== 7) begin
      n_err++;
      $display("FAIL directed_count: got %0d expected 7", k);
    end
  endtask

  task automatic test_stall();
    logic [31:0] vals[3];
    int j = 0;
    foreach (vals[i]) vals[i] = $urandom;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, vals[i]);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, $urandom);
      n_checks++;
      if (bus.out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL stall_valid[%0d]: got %b expected 1", i, bus.out_valid);
      end
      n_checks++;
      if (bus.y !== ref_int(vals[0])) begin
        n_err++;
        $display("FAIL stall_y[%0d]: got %h expected %h", i, bus.y, ref_int(vals[0]));
      end
    end
    j = 1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      n_checks++;
      if (bus.out_valid !== (i < 2)) begin
        n_err++;
        $display("FAIL stall_release_valid[%0d]: got %b expected %b", i, bus.out_valid, (i < 2));
      end
      if (i < 2) begin
        n_checks++;
        if (bus.y !== ref_int(vals[j])) begin
          n_err++;
          $display("FAIL stall_release_y[%0d]: got %h expected %h", j, bus.y, ref_int(vals[j]));
        end
        j++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, $urandom | 32'h1);
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_valid: got %b expected 0", bus.out_valid);
    end
    n_checks++;
    if (bus.y !== 32'h0) begin
      n_err++;
      $display("FAIL midreset_y: got %h expected 00000000", bus.y);
    end
    q_val.delete();
    q_age.delete();
    @(negedge clk);
    rstn = 1'b1;
    v = $urandom;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) tick(1'b0, 1'b1, v);
      else        tick(1'b0, 1'b0, 32'h0);
      n_checks++;
      if (bus.out_valid !== (i == 2)) begin
        n_err++;
        $display("FAIL postreset_valid[%0d]: got %b expected %b", i, bus.out_valid, (i == 2));
      end
    end
    n_checks++;
    if (bus.y !== ref_int(v)) begin
      n_err++;
      $display("FAIL postreset_y: got %h expected %h", bus.y, ref_int(v));
    end
  endtask

  task automatic test_random();
    logic        st, iv;
    logic [31:0] xv;
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(0, 3) == 0) && (i < 2990);
      iv = ($urandom_range(0, 3) != 0) && (i < 2990);
      case ($urandom_range(0, 3))
        0:       xv = $urandom_range(0, 255);
        1:       xv = 32'(-int'($urandom_range(0, 1 << 25)));
        default: xv = $urandom;
      endcase
      tick(st, iv, xv);
      n_checks++;
      if (bus.out_valid !== exp_valid) begin
        n_err++;
        $display("FAIL random_valid[%0d]: got %b expected %b", i, bus.out_valid, exp_valid);
      end
      if (exp_valid) begin
        n_checks++;
        if (bus.y !== ref_int(exp_x)) begin
          n_err++;
          $display("FAIL random_y x=%h: got %h expected %h", exp_x, bus.y, ref_int(exp_x));
        end
      end
    end
  endtask

  // Values as produced by a float-to-nearest-int stage for |f| < 2^23.
  task automatic test_round_trip();
    int  ip, n;
    real f;
    for (int i = 0; i < 303; i++) begin
      if (i < 300) begin
        ip = int'($urandom_range(0, 16777214)) - 8388607;
        f  = real'(ip) + real'($urandom_range(0, 999)) / 1000.0;
        n  = int'(f);
        tick(1'b0, 1'b1, 32'(n));
      end else begin
        tick(1'b0, 1'b0, 32'h0);
      end
      n_checks++;
      if (bus.out_valid !== exp_valid) begin
        n_err++;
        $display("FAIL roundtrip_valid[%0d]: got %b expected %b", i, bus.out_valid, exp_valid);
      end
      if (exp_valid) begin
        n_checks++;
        if (bus.y !== ref_dbl(int'(exp_x))) begin
          n_err++;
          $display("FAIL roundtrip_y n=%0d: got %h expected %h", int'(exp_x), bus.y, ref_dbl(int'(exp_x)));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_random();
    test_round_trip();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
